// File: rtl/reg_bank_write_sched.sv
// Round-robin write scheduler for a bank of 74273-style registers: setup, CP strobe, hold, clear.
// Optional WRITE_VERIFY_EN adds REG_Q read-back compare and a sticky WR_ERR flag.
module reg_bank_write_sched #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NUM_REQ-1:0]         REQ,
    input  logic [NUM_REQ*ADDR_W-1:0]  REQ_ADDR,
    input  logic [NUM_REQ*DATA_W-1:0]  REQ_DATA,
    output logic [NUM_REQ-1:0]         GNT,
    input  logic                       CLR_REQ,
    output logic                       CLR_ACK,
    output logic [DATA_W-1:0]          BUS_D,
    output logic [NUM_REGS-1:0]        REG_CP,
    output logic                       REG_N_MR,
`ifdef WRITE_VERIFY_EN
    input  logic [NUM_REGS*DATA_W-1:0] REG_Q,
    output logic                       WR_ERR,
`endif
    output logic                       BUSY
);

    localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned HCNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StClear} state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]    win_q, win_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [HCNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [DATA_W-1:0]   bus_d_q, bus_d_d;
    logic [NUM_REGS-1:0] cp_q, cp_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic                n_mr_q, n_mr_d;
    logic                clr_ack_q, clr_ack_d;
    logic                busy_q, busy_d;

    logic                found_hi, found_lo;
    logic [PTR_W-1:0]    idx_hi, idx_lo, arb_idx;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic [NUM_REQ-1:0]  win_oh;
    logic [NUM_REGS-1:0] addr_oh;
    logic [PTR_W-1:0]    win_next;

    // Round-robin: first request at or above rr_ptr, else lowest index overall (wrap).
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!found_hi && REQ[j] && (PTR_W'(j) >= rr_ptr_q)) begin
                found_hi = 1'b1;
                idx_hi   = PTR_W'(j);
            end
            if (!found_lo && REQ[j]) begin
                found_lo = 1'b1;
                idx_lo   = PTR_W'(j);
            end
        end
        arb_idx = found_hi ? idx_hi : idx_lo;
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        win_oh   = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (arb_idx == PTR_W'(j)) begin
                sel_addr = REQ_ADDR[j*ADDR_W +: ADDR_W];
                sel_data = REQ_DATA[j*DATA_W +: DATA_W];
            end
            win_oh[j] = (win_q == PTR_W'(j));
        end
    end

    // Out-of-range addresses decode to no strobe at all.
    always_comb begin
        addr_oh = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            addr_oh[r] = (addr_q == ADDR_W'(r));
        end
    end

    assign win_next = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        win_d      = win_q;
        addr_d     = addr_q;
        data_d     = data_q;
        hold_cnt_d = hold_cnt_q;
        bus_d_d    = bus_d_q;
        cp_d       = '0;
        gnt_d      = '0;
        n_mr_d     = 1'b1;
        clr_ack_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (CLR_REQ) begin
                    state_d   = StClear;
                    n_mr_d    = 1'b0;
                    clr_ack_d = 1'b1;
                end else if (|REQ) begin
                    state_d = StSetup;
                    win_d   = arb_idx;
                    addr_d  = sel_addr;
                    data_d  = sel_data;
                    bus_d_d = sel_data;
                end
            end
            StSetup: begin
                state_d = StStrobe;
                cp_d    = addr_oh;
            end
            StStrobe: begin
                state_d    = StHold;
                hold_cnt_d = '0;
                if (HOLD_LAST == '0) begin
                    gnt_d = win_oh;
                end
            end
            StHold: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d  = StIdle;
                    rr_ptr_d = win_next;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                    if (hold_cnt_d == HOLD_LAST) begin
                        gnt_d = win_oh;
                    end
                end
            end
            StClear: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    // Reset holds the bank cleared (n_mr low) and drops any strobe at once.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            win_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            hold_cnt_q <= '0;
            bus_d_q    <= '0;
            cp_q       <= '0;
            gnt_q      <= '0;
            n_mr_q     <= 1'b0;
            clr_ack_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            win_q      <= win_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            hold_cnt_q <= hold_cnt_d;
            bus_d_q    <= bus_d_d;
            cp_q       <= cp_d;
            gnt_q      <= gnt_d;
            n_mr_q     <= n_mr_d;
            clr_ack_q  <= clr_ack_d;
            busy_q     <= busy_d;
        end
    end

    assign GNT      = gnt_q;
    assign CLR_ACK  = clr_ack_q;
    assign BUS_D    = bus_d_q;
    assign REG_CP   = cp_q;
    assign REG_N_MR = n_mr_q;
    assign BUSY     = busy_q;

`ifdef WRITE_VERIFY_EN
    logic err_q, err_d, q_mismatch;

    // Read-back compare happens in the last hold cycle, after the strobe has landed.
    always_comb begin
        q_mismatch = 1'b0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if ((addr_q == ADDR_W'(r)) && (REG_Q[r*DATA_W +: DATA_W] != data_q)) begin
                q_mismatch = 1'b1;
            end
        end
        err_d = err_q | ((state_q == StHold) && (hold_cnt_q == HOLD_LAST) && q_mismatch);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign WR_ERR = err_q;
`endif

endmodule

// File: tb/tb_reg_bank_write_sched.sv
// Scoreboard bench for reg_bank_write_sched: transaction-level model predicts grant/clear order
// and timing; a separate monitor checks DUT outputs against the expected queue.
module tb_reg_bank_write_sched;

    localparam int NUM_REQ  = 4;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 8;
    localparam int HOLD     = 1;

    logic                        CLK = 1'b0;
    logic                        RST;
    logic [NUM_REQ-1:0]          REQ;
    logic [NUM_REQ*ADDR_W-1:0]   REQ_ADDR;
    logic [NUM_REQ*DATA_W-1:0]   REQ_DATA;
    logic [NUM_REQ-1:0]          GNT;
    logic                        CLR_REQ;
    logic                        CLR_ACK;
    logic [DATA_W-1:0]           BUS_D;
    logic [NUM_REGS-1:0]         REG_CP;
    logic                        REG_N_MR;
    logic                        BUSY;
`ifdef WRITE_VERIFY_EN
    logic [NUM_REGS*DATA_W-1:0]  REG_Q;
    logic                        WR_ERR;
    logic [DATA_W-1:0]           bank [NUM_REGS];
    bit                          corrupt3 = 0;
`endif

    logic [ADDR_W-1:0] req_addr [NUM_REQ];
    logic [DATA_W-1:0] req_data [NUM_REQ];

    typedef struct {
        bit is_clr;
        int cyc;
        int who;
        int addr;
        int data;
    } exp_t;

    exp_t expq[$];
    int   gnt_log[$];
    int   gnt_cyc_log[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   m_next_idle = 0;
    int   m_rr = 0;
    int   m_win = 0;
    bit   m_wr = 0;

    reg_bank_write_sched #(
        .NUM_REQ     (NUM_REQ),
        .NUM_REGS    (NUM_REGS),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .REQ      (REQ),
        .REQ_ADDR (REQ_ADDR),
        .REQ_DATA (REQ_DATA),
        .GNT      (GNT),
        .CLR_REQ  (CLR_REQ),
        .CLR_ACK  (CLR_ACK),
        .BUS_D    (BUS_D),
        .REG_CP   (REG_CP),
        .REG_N_MR (REG_N_MR),
`ifdef WRITE_VERIFY_EN
        .REG_Q    (REG_Q),
        .WR_ERR   (WR_ERR),
`endif
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            REQ_ADDR[i*ADDR_W +: ADDR_W] = req_addr[i];
            REQ_DATA[i*DATA_W +: DATA_W] = req_data[i];
        end
    end

`ifdef WRITE_VERIFY_EN
    // Register bank: captures BUS_D while its CP is high, cleared by REG_N_MR low.
    initial forever begin
        @(negedge CLK);
        for (int r = 0; r < NUM_REGS; r++) begin
            if (!REG_N_MR) bank[r] = '0;
            else if (REG_CP[r]) bank[r] = (corrupt3 && r == 3) ? '0 : BUS_D;
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) REG_Q[r*DATA_W +: DATA_W] = bank[r];
    end
`endif

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: pops the expected queue whenever the DUT grants or acknowledges a clear.
    initial begin : monitor
        logic [NUM_REGS-1:0] cap_cp;
        logic [DATA_W-1:0]   cap_bus;
        int                  cap_cyc;
        int                  gi;
        exp_t                e;
        cap_cp  = '0;
        cap_bus = '0;
        cap_cyc = 0;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (REG_CP != '0) begin
                    chk("cp_onehot", 32'($countones(REG_CP)), 32'd1);
                    chk("cp_during_clear", 32'(REG_N_MR), 32'd1);
                    cap_cp  = REG_CP;
                    cap_bus = BUS_D;
                    cap_cyc = cyc;
                end
                if (expq.size() > 0) begin
                    chk("deadline_missed", 32'(expq[0].cyc < cyc), 32'd0);
                    if (expq[0].cyc < cyc) void'(expq.pop_front());
                end
                if (GNT != '0 || CLR_ACK) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_output", 32'({GNT, CLR_ACK}), 32'd0);
                    end else begin
                        e = expq.pop_front();
                        if (e.is_clr) begin
                            chk("clr_ack", 32'(CLR_ACK), 32'd1);
                            chk("clr_n_mr", 32'(REG_N_MR), 32'd0);
                            chk("clr_gnt_cp", 32'({GNT, REG_CP}), 32'd0);
                            chk("clr_cycle", 32'(cyc), 32'(e.cyc));
                        end else begin
                            gi = -1;
                            for (int i = 0; i < NUM_REQ; i++) if (GNT[i]) gi = i;
                            chk("gnt_vector", 32'(GNT), 32'(1) << e.who);
                            chk("gnt_cycle", 32'(cyc), 32'(e.cyc));
                            chk("gnt_no_ack", 32'(CLR_ACK), 32'd0);
                            chk("cp_pattern", 32'(cap_cp),
                                (e.addr < NUM_REGS) ? (32'(1) << e.addr) : 32'd0);
                            chk("cp_cycle", 32'(cap_cyc), 32'(e.cyc - HOLD));
                            chk("bus_at_cp", 32'(cap_bus), 32'(e.data));
                            chk("bus_at_gnt", 32'(BUS_D), 32'(e.data));
                            gnt_log.push_back(gi);
                            gnt_cyc_log.push_back(cyc);
                            cap_cp = '0;
                        end
                    end
                end
            end
        end
    end

    task automatic at_neg();
        @(negedge CLK);
        for (int i = 0; i < NUM_REQ; i++) if (GNT[i]) REQ[i] = 1'b0;
        if (CLR_ACK) CLR_REQ = 1'b0;
    endtask

    // Reference model: acts once per idle slot, clear first, else round-robin winner.
    task automatic commit();
        exp_t e;
        int   w;
        if (!RST && cyc >= m_next_idle) begin
            if (CLR_REQ) begin
                e = '{is_clr: 1, cyc: cyc + 1, who: 0, addr: 0, data: 0};
                expq.push_back(e);
                m_next_idle = cyc + 2;
                m_wr = 0;
            end else if (REQ != '0) begin
                w = -1;
                for (int k = 0; k < NUM_REQ; k++)
                    if (w < 0 && REQ[(m_rr + k) % NUM_REQ]) w = (m_rr + k) % NUM_REQ;
                e = '{is_clr: 0, cyc: cyc + 2 + HOLD, who: w,
                      addr: int'(req_addr[w]), data: int'(req_data[w])};
                expq.push_back(e);
                m_next_idle = cyc + 3 + HOLD;
                m_rr = (w + 1) % NUM_REQ;
                m_win = w;
                m_wr = 1;
            end
        end
    endtask

    task automatic raise(input int i, input int a, input int d);
        REQ[i] = 1'b1;
        req_addr[i] = ADDR_W'(a);
        req_data[i] = DATA_W'(d);
    endtask

    task automatic step();
        at_neg();
        commit();
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            step();
            done = (REQ == '0) && !CLR_REQ && (expq.size() == 0) && (cyc >= m_next_idle);
        end
        chk("drain_timeout", 32'(done), 32'd1);
    endtask

    task automatic release_rst();
        RST = 1'b0;
        m_next_idle = cyc;
        m_rr = 0;
        m_wr = 0;
    endtask

    initial begin : timeout
        #500000;
        $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};
        RST = 1'b1;
        REQ = '0;
        CLR_REQ = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i] = '0;
            req_data[i] = '0;
        end

        // Reset: bank held cleared, every other output low.
        repeat (3) begin
            @(negedge CLK);
            chk("rst_n_mr", 32'(REG_N_MR), 32'd0);
            chk("rst_outputs", 32'({BUSY, GNT, CLR_ACK, REG_CP, BUS_D}), 32'd0);
        end
        release_rst();
        @(negedge CLK);
        chk("post_rst_n_mr", 32'(REG_N_MR), 32'd1);
        chk("post_rst_outputs", 32'({BUSY, GNT, CLR_ACK, REG_CP, BUS_D}), 32'd0);

        // All four requesting continuously: order 0,1,2,3,0 at 3+HOLD cycle spacing.
        at_neg();
        for (int i = 0; i < NUM_REQ; i++) raise(i, i, 8'h10 * i + 1);
        commit();
        for (int n = 0; n < 24; n++) begin
            at_neg();
            for (int i = 0; i < NUM_REQ; i++)
                if (!REQ[i] && gnt_log.size() < 5) raise(i, i + 4, 8'h10 * i + n);
            commit();
        end
        drain();
        chk("rr_count", 32'(gnt_log.size() >= 5), 32'd1);
        if (gnt_log.size() >= 5) begin
            for (int k = 0; k < 5; k++) chk("rr_order", 32'(gnt_log[k]), 32'(exp_order[k]));
            for (int k = 0; k < 4; k++)
                chk("rr_spacing", 32'(gnt_cyc_log[k+1] - gnt_cyc_log[k]), 32'(3 + HOLD));
        end

        // Single write, requester 2 -> reg 5, checking each phase.
        at_neg();
        raise(2, 5, 8'hA5);
        commit();
        step();
        chk("setup_bus", 32'(BUS_D), 32'hA5);
        chk("setup_cp", 32'(REG_CP), 32'd0);
        chk("setup_busy", 32'(BUSY), 32'd1);
        step();
        chk("strobe_cp", 32'(REG_CP), 32'b0010_0000);
        step();
        chk("hold_cp", 32'(REG_CP), 32'd0);
        chk("hold_gnt", 32'(GNT), 32'b0100);
        drain();
        chk("idle_busy", 32'(BUSY), 32'd0);

        // Clear together with a request in IDLE: clear wins, write follows.
        at_neg();
        CLR_REQ = 1'b1;
        raise(0, 1, 8'h5A);
        commit();
        at_neg();
        chk("clr_first_n_mr", 32'(REG_N_MR), 32'd0);
        chk("clr_first_ack", 32'(CLR_ACK), 32'd1);
        chk("clr_first_cp", 32'(REG_CP), 32'd0);
        commit();
        drain();

        // Clear raised during STROBE: write finishes first.
        at_neg();
        raise(1, 6, 8'hC3);
        commit();
        step();
        at_neg();
        chk("strobe_cp6", 32'(REG_CP), 32'b0100_0000);
        CLR_REQ = 1'b1;
        commit();
        drain();

        // Reset during STROBE aborts the write with no grant.
        at_neg();
        raise(1, 2, 8'h77);
        commit();
        step();
        at_neg();
        chk("pre_abort_cp", 32'(REG_CP), 32'b0000_0100);
        RST = 1'b1;
        REQ = '0;
        expq.delete();
        @(negedge CLK);
        chk("abort_cp", 32'(REG_CP), 32'd0);
        chk("abort_n_mr", 32'(REG_N_MR), 32'd0);
        chk("abort_gnt_busy", 32'({GNT, BUSY}), 32'd0);
        release_rst();
        @(negedge CLK);
        chk("after_abort_n_mr", 32'(REG_N_MR), 32'd1);
        chk("after_abort_idle", 32'({GNT, BUSY}), 32'd0);
        drain();

        // Randomized traffic with occasional clears and scrambling of latched inputs.
        for (int n = 0; n < 1500; n++) begin
            at_neg();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!REQ[i] && $urandom_range(0, 3) == 0)
                    raise(i, int'($urandom_range(0, NUM_REGS - 1)), int'($urandom_range(0, 255)));
                else if (REQ[i] && m_wr && i == m_win && cyc < m_next_idle && $urandom_range(0, 1) == 1) begin
                    req_addr[i] = ADDR_W'($urandom_range(0, NUM_REGS - 1));
                    req_data[i] = DATA_W'($urandom_range(0, 255));
                end
            end
            if (!CLR_REQ && $urandom_range(0, 24) == 0) CLR_REQ = 1'b1;
            commit();
        end
        drain();

`ifdef WRITE_VERIFY_EN
        chk("wr_err_clean", 32'(WR_ERR), 32'd0);
        corrupt3 = 1;
        at_neg();
        raise(0, 3, 8'h3C);
        commit();
        step();
        step();
        at_neg();
        chk("verify_gnt", 32'(GNT), 32'b0001);
        chk("verify_err_at_gnt", 32'(WR_ERR), 32'd0);
        commit();
        step();
        chk("verify_err_set", 32'(WR_ERR), 32'd1);
        repeat (5) step();
        chk("verify_err_sticky", 32'(WR_ERR), 32'd1);
        corrupt3 = 0;
        RST = 1'b1;
        @(negedge CLK);
        chk("verify_err_rst", 32'(WR_ERR), 32'd0);
        release_rst();
        drain();
`endif

        chk("queue_empty", 32'(expq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
